// File: rtl/refill_controller_pkg.sv
// Shared types and line-geometry constants for the cache refill path.
// Geometry macros normally come from cache.svh; the fallbacks keep this slice standalone.
`ifndef CACHE_B
`define CACHE_B 6
`endif
`ifndef CACHE_E
`define CACHE_E 4
`endif

package refill_controller_pkg;

    localparam int unsigned OFFSET_W       = `CACHE_B;
    localparam int unsigned DEF_LINE_WORDS = 2 ** (OFFSET_W - 2);
    localparam int unsigned DEF_SET_SIZE   = `CACHE_E;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} refill_state_t;

endpackage

// File: rtl/refill_controller.sv
// Cache miss handler: optional dirty write-back of the chosen victim, then a word-by-word
// refill of that line from memory, ending with a one-cycle fill/done strobe.
module refill_controller
    import refill_controller_pkg::*;
#(
    parameter int unsigned SET_SIZE   = DEF_SET_SIZE,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned CNT_W      = $clog2(LINE_WORDS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                miss_i,
    input  logic [31:0]         addr_i,
    input  logic [SET_SIZE-1:0] victim_line_i,
    input  logic                victim_dirty_i,
    input  logic [31:0]         victim_addr_i,
    output logic [CNT_W-1:0]    line_word_o,
    input  logic [31:0]         line_rdata_i,
    output logic [SET_SIZE-1:0] line_we_o,
    output logic [31:0]         line_wdata_o,
    output logic                line_fill_o,
    output logic                mem_req_o,
    output logic                mem_wen_o,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    input  logic [31:0]         mem_rdata_i,
    input  logic                mem_ready_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

    refill_state_t       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         miss_base_q, victim_base_q;
    logic [SET_SIZE-1:0] victim_q;
    logic                latch;
    logic [31:0]         word_off;
    logic                unused_offset;

    assign word_off      = {{(30 - CNT_W){1'b0}}, cnt_q, 2'b00};
    assign unused_offset = ^{addr_i[CNT_W+1:0], victim_addr_i[CNT_W+1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            miss_base_q   <= '0;
            victim_base_q <= '0;
            victim_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                miss_base_q   <= {addr_i[31:CNT_W+2], {(CNT_W + 2){1'b0}}};
                victim_base_q <= {victim_addr_i[31:CNT_W+2], {(CNT_W + 2){1'b0}}};
                victim_q      <= victim_line_i;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latch        = 1'b0;
        line_word_o  = '0;
        line_we_o    = '0;
        line_wdata_o = '0;
        line_fill_o  = 1'b0;
        mem_req_o    = 1'b0;
        mem_wen_o    = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        done_o       = 1'b0;
        busy_o       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (miss_i) begin
                    latch   = 1'b1;
                    cnt_d   = '0;
                    state_d = victim_dirty_i ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_wen_o   = 1'b1;
                line_word_o = cnt_q;
                mem_wdata_o = line_rdata_i;
                mem_addr_o  = victim_base_q + word_off;
                if (mem_ready_i) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = REFILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            REFILL: begin
                mem_req_o   = 1'b1;
                line_word_o = cnt_q;
                mem_addr_o  = miss_base_q + word_off;
                if (mem_ready_i) begin
                    line_we_o    = victim_q;
                    line_wdata_o = mem_rdata_i;
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                line_fill_o = 1'b1;
                done_o      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
